hs32_wb_loader: RTL
===================

// Module: hs32_wb_loader
// PURPOSE
//  Wishbone classic responder behind the caravel wbs_* slave port. Management SoC writes the
//  HS32 program image into a local word RAM, then writes CTRL to release the core from reset.
//  While the core runs, it owns the RAM through a single-cycle request/ack port.
//  Sits between user_project_wrapper wbs_* pins and the core instruction/data memory.
// PARAMETERS
//  AW         8             RAM word-address width; RAM depth = 2**AW words of 32 bits
//  CTRL_ADR   32'h0000FFFC  byte address of control/status register
// PORTS
//  wb_clk_i     in   1   clock; all logic on rising edge
//  wb_rst_ni    in   1   asynchronous active-low reset
//  wbs_stb_i    in   1   Wishbone strobe
//  wbs_cyc_i    in   1   Wishbone cycle
//  wbs_we_i     in   1   1=write, 0=read
//  wbs_sel_i    in   4   byte lane enables, bit n -> dat[8n+7:8n]
//  wbs_adr_i    in   32  byte address; bits [1:0] ignored
//  wbs_dat_i    in   32  write data
//  wbs_ack_o    out  1   acknowledge, one-cycle pulse
//  wbs_dat_o    out  32  read data, valid when wbs_ack_o=1
//  core_rst_no  out  1   core reset, active low; 0 = core halted
//  core_stb_i   in   1   core memory request
//  core_we_i    in   1   core write enable
//  core_sel_i   in   4   core byte enables
//  core_adr_i   in   AW  core word address
//  core_dat_i   in   32  core write data
//  core_dat_o   out  32  core read data, valid with core_ack_o
//  core_ack_o   out  1   core acknowledge
// BEHAVIOUR
//  - Reset values: wbs_ack_o=0, wbs_dat_o=0, core_rst_no=0 (halted), core_ack_o=0, core_dat_o=0.
//    RAM contents are not reset and survive wb_rst_ni.
//  - WB handshake: ack <= stb & cyc & ~ack. Latency: ack exactly 1 cycle after the request is sampled.
//    Ack never holds 2 cycles, so a held strobe gets ack on alternate cycles.
//    Strobe that drops before being sampled produces no ack.
//  - Address decode: adr == CTRL_ADR -> CTRL. adr[AW+1:2] selects the RAM word when adr[31:AW+2]==0.
//    Any other address -> acked, write ignored, read data 0. No err/rty signals.
//  - RAM write (WB): only while core_rst_no=0. Lanes follow wbs_sel_i. sel=0 -> acked with no change.
//    While the core runs, WB RAM writes are acked and dropped (write protect).
//  - CTRL write: bit0 -> core_rst_no, with sel[0]=1 required. Other bits are ignored.
//    CTRL read: {30'b0, core_running, core_rst_no}; core_running=1 from the cycle after release.
//  - Core port: active only while core_rst_no=1. core_ack_o = 1 cycle after core_stb_i, pulse.
//    Read data is the registered RAM word. Writes follow core_sel_i.
//    core_stb_i while halted -> no ack.
//  - Ownership: WB owns the RAM when halted and the core owns it when running, so no simultaneous access.
//    A WB RAM access that coincides with the CTRL-release cycle completes against the old owner (WB).
//  - CTRL write of 0 while running: core_rst_no falls the next cycle. A pending core ack is squashed.
//  - Async reset mid-transaction: ack dropped immediately. Master must restart the cycle.
// CONFIGURATION
//  HS32_LOADER_READBACK_EN defined: WB reads of RAM return stored word (any time).
//  Not defined: WB RAM reads are acked with wbs_dat_o=0 (saves read mux); CTRL reads still valid.
// TESTING
//  1. Reset: hold wb_rst_ni=0 -> all outputs 0. Release -> core_rst_no stays 0.
//  2. Load: write 8 words 0x2400FF00.. to byte adr 0x00..0x1C, stb pulsed 1 cycle
//     -> 8 acks, each 1 cycle after stb; readback (READBACK_EN) matches.
//  3. Byte lanes: word 0 = 0x11223344, write sel=4'b0010 dat=0xAABBCCDD -> reads 0x1122CC44.
//  4. Release: write CTRL_ADR=1 -> core_rst_no=1 next cycle.
//     core read adr 1 -> core_ack_o next cycle with 0x24100019. CTRL reads 0x3.
//  5. Protect: while running, WB write 0xDEADBEEF to adr 0x04 -> acked; core read adr 1 still 0x24100019.
//  6. Edge: write to 0x00010000 -> acked, no effect. Async reset mid-ack -> ack falls at once.
//     Core halted, RAM retained.

Source files
------------

// File: rtl/hs32_wb_loader.sv
// Wishbone program loader and RAM arbiter for the HS32 core: WB owns the word RAM while the core is
// halted, the core owns it while running. Define HS32_LOADER_READBACK_EN to enable WB reads of RAM.
module hs32_wb_loader #(
  parameter int          AW       = 8,
  parameter logic [31:0] CTRL_ADR = 32'h0000FFFC
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          core_rst_no,
  input  logic          core_stb_i,
  input  logic          core_we_i,
  input  logic [3:0]    core_sel_i,
  input  logic [AW-1:0] core_adr_i,
  input  logic [31:0]   core_dat_i,
  output logic [31:0]   core_dat_o,
  output logic          core_ack_o
);

  localparam int DEPTH = 1 << AW;

  logic [31:0]   ram_q [DEPTH];

  logic          wb_ack_q, wb_ack_d;
  logic [31:0]   wb_dat_q, wb_dat_d;
  logic          core_rst_q, core_rst_d;
  logic          running_q, running_d;
  logic          core_ack_q, core_ack_d;
  logic [31:0]   core_dat_q, core_dat_d;

  logic          wb_req, is_ctrl, is_ram, core_req;
  logic [AW-1:0] wb_word;
  logic          ram_we;
  logic [AW-1:0] ram_adr;
  logic [31:0]   ram_wdat;
  logic [3:0]    ram_sel;
  logic          unused_adr_lsb;

  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  always_comb begin
    wb_req     = wbs_stb_i & wbs_cyc_i & ~wb_ack_q;
    is_ctrl    = (wbs_adr_i == CTRL_ADR);
    is_ram     = ~is_ctrl && (wbs_adr_i[31:AW+2] == '0);
    wb_word    = wbs_adr_i[AW+1:2];
    core_req   = core_stb_i & core_rst_q;

    wb_ack_d   = wb_req;
    wb_dat_d   = '0;
    core_rst_d = core_rst_q;
    running_d  = core_rst_q;
    core_dat_d = core_dat_q;
    ram_we     = 1'b0;
    ram_adr    = core_adr_i;
    ram_wdat   = core_dat_i;
    ram_sel    = core_sel_i;

    if (wb_req) begin
      if (is_ctrl) begin
        if (wbs_we_i && wbs_sel_i[0]) core_rst_d = wbs_dat_i[0];
        else if (!wbs_we_i)           wb_dat_d   = {30'b0, running_q, core_rst_q};
      end else if (is_ram) begin
        // Ownership follows the registered reset, so the release cycle still belongs to WB.
        if (wbs_we_i && !core_rst_q) begin
          ram_we   = 1'b1;
          ram_adr  = wb_word;
          ram_wdat = wbs_dat_i;
          ram_sel  = wbs_sel_i;
        end
`ifdef HS32_LOADER_READBACK_EN
        else if (!wbs_we_i) wb_dat_d = ram_q[wb_word];
`endif
      end
    end

    // A CTRL halt in the same cycle squashes the core's ack and its write.
    core_ack_d = core_req & core_rst_d;
    if (core_req && core_rst_d) begin
      if (core_we_i) ram_we     = 1'b1;
      else           core_dat_d = ram_q[core_adr_i];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_q   <= 1'b0;
      wb_dat_q   <= '0;
      core_rst_q <= 1'b0;
      running_q  <= 1'b0;
      core_ack_q <= 1'b0;
      core_dat_q <= '0;
    end else begin
      wb_ack_q   <= wb_ack_d;
      wb_dat_q   <= wb_dat_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
      core_ack_q <= core_ack_d;
      core_dat_q <= core_dat_d;
    end
  end

  // RAM has no reset so the loaded image survives wb_rst_ni.
  always_ff @(posedge wb_clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && ram_sel[i]) ram_q[ram_adr][8*i +: 8] <= ram_wdat[8*i +: 8];
    end
  end

  assign wbs_ack_o   = wb_ack_q;
  assign wbs_dat_o   = wb_dat_q;
  assign core_rst_no = core_rst_q;
  assign core_ack_o  = core_ack_q;
  assign core_dat_o  = core_dat_q;

endmodule
